// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the MEM stage: FSM states, word/register widths
// and the latched copy of an outstanding data-memory access.
package mem_access_stage_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic              regwrite;
    logic              memtoreg;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [REG_W-1:0]  write_reg;
  } access_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready port; the MEM stage is the master, the memory the slave.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the control bits so the
// data fields keep their last values.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic              regwrite_i,
  input  logic              memtoreg_i,
  input  logic [WORD_W-1:0] read_data_i,
  input  logic [WORD_W-1:0] alu_result_i,
  input  logic [REG_W-1:0]  write_reg_i,
  output logic              regwrite_o,
  output logic              memtoreg_o,
  output logic [WORD_W-1:0] read_data_o,
  output logic [WORD_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  write_reg_o
);
  logic              regwrite_q, memtoreg_q;
  logic [WORD_W-1:0] read_data_q, alu_result_q;
  logic [REG_W-1:0]  write_reg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
    end else if (load_i) begin
      regwrite_q   <= regwrite_i;
      memtoreg_q   <= memtoreg_i;
      read_data_q  <= read_data_i;
      alu_result_q <= alu_result_i;
      write_reg_q  <= write_reg_i;
    end else if (bubble_i) begin
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
    end
  end

  assign regwrite_o   = regwrite_q;
  assign memtoreg_o   = memtoreg_q;
  assign read_data_o  = read_data_q;
  assign alu_result_o = alu_result_q;
  assign write_reg_o  = write_reg_q;
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues data-memory accesses, stalls upstream while one is
// outstanding, resolves branches and feeds the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               regwrite_in,
  input  logic               memtoreg_in,
  input  logic               branch_in,
  input  logic               memread_in,
  input  logic               memwrite_in,
  input  logic               zero_in,
  input  logic [WORD_W-1:0]  alu_result_in,
  input  logic [WORD_W-1:0]  write_data_in,
  input  logic [REG_W-1:0]   write_reg_in,
  input  logic [WORD_W-1:0]  branchaddr_in,
  output logic               pcsrc,
  output logic [WORD_W-1:0]  branch_target,
  output logic               stall_out,
  mem_access_stage_if.master dmem,
  output logic               regwrite_out,
  output logic               memtoreg_out,
  output logic [WORD_W-1:0]  read_data_out,
  output logic [WORD_W-1:0]  alu_result_out,
  output logic [REG_W-1:0]   write_reg_out,
  output logic               addr_err,
  output logic               bus_err
);
  state_t            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  access_t           lat_q, lat_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic              memop, aligned, timeout_hit;
  logic              req, we, stall, wb_load;
  logic [WORD_W-1:0] addr, wdata;
  logic              wb_regwrite, wb_memtoreg;
  logic [WORD_W-1:0] wb_read_data, wb_alu_result;
  logic [REG_W-1:0]  wb_write_reg;

  assign memop       = memread_in | memwrite_in;
  assign aligned     = (alu_result_in[1:0] == 2'b00);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    st_d          = st_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    addr_err_d    = 1'b0;
    bus_err_d     = 1'b0;
    req           = 1'b0;
    we            = lat_q.we;
    addr          = lat_q.addr;
    wdata         = lat_q.wdata;
    stall         = 1'b0;
    wb_load       = 1'b0;
    wb_regwrite   = regwrite_in;
    wb_memtoreg   = memtoreg_in;
    wb_read_data  = '0;
    wb_alu_result = alu_result_in;
    wb_write_reg  = write_reg_in;
    unique case (st_q)
      ST_IDLE: begin
        cnt_d = '0;
        we    = memwrite_in;
        addr  = alu_result_in;
        wdata = write_data_in;
        if (memop && aligned) begin
          req = 1'b1;
          if (dmem.dmem_ready) begin
            wb_load      = 1'b1;
            wb_read_data = dmem.dmem_rdata;
          end else begin
            stall = 1'b1;
            lat_d = '{we: memwrite_in, regwrite: regwrite_in, memtoreg: memtoreg_in,
                      addr: alu_result_in, wdata: write_data_in, write_reg: write_reg_in};
            st_d  = ST_WAIT;
          end
        end else if (memop) begin
          addr_err_d = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_WAIT: begin
        req           = 1'b1;
        wb_regwrite   = lat_q.regwrite;
        wb_memtoreg   = lat_q.memtoreg;
        wb_read_data  = dmem.dmem_rdata;
        wb_alu_result = lat_q.addr;
        wb_write_reg  = lat_q.write_reg;
        // A late ready in the timeout cycle still completes the access.
        if (dmem.dmem_ready) begin
          wb_load = 1'b1;
          st_d    = ST_IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          st_d      = ST_IDLE;
          cnt_d     = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // The pending request must vanish the moment reset asserts, even mid-wait.
  assign dmem.dmem_req   = req & reset;
  assign dmem.dmem_we    = we;
  assign dmem.dmem_addr  = addr;
  assign dmem.dmem_wdata = wdata;

  assign stall_out     = stall;
  assign pcsrc         = (st_q == ST_IDLE) & branch_in & zero_in;
  assign branch_target = branchaddr_in;
  assign addr_err      = addr_err_q;
  assign bus_err       = bus_err_q;

  mem_wb_reg u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .load_i       (wb_load),
    .bubble_i     (!wb_load),
    .regwrite_i   (wb_regwrite),
    .memtoreg_i   (wb_memtoreg),
    .read_data_i  (wb_read_data),
    .alu_result_i (wb_alu_result),
    .write_reg_i  (wb_write_reg),
    .regwrite_o   (regwrite_out),
    .memtoreg_o   (memtoreg_out),
    .read_data_o  (read_data_out),
    .alu_result_o (alu_result_out),
    .write_reg_o  (write_reg_out)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regwrite_in, memtoreg_in, branch_in, memread_in, memwrite_in, zero_in;
  logic [31:0] alu_result_in, write_data_in, branchaddr_in;
  logic [4:0]  write_reg_in;
  logic        pcsrc, stall_out, regwrite_out, memtoreg_out, addr_err, bus_err;
  logic [31:0] branch_target, read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  mem_access_stage_if dif();

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .regwrite_in    (regwrite_in),
    .memtoreg_in    (memtoreg_in),
    .branch_in      (branch_in),
    .memread_in     (memread_in),
    .memwrite_in    (memwrite_in),
    .zero_in        (zero_in),
    .alu_result_in  (alu_result_in),
    .write_data_in  (write_data_in),
    .write_reg_in   (write_reg_in),
    .branchaddr_in  (branchaddr_in),
    .pcsrc          (pcsrc),
    .branch_target  (branch_target),
    .stall_out      (stall_out),
    .dmem           (dif),
    .regwrite_out   (regwrite_out),
    .memtoreg_out   (memtoreg_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .write_reg_out  (write_reg_out),
    .addr_err       (addr_err),
    .bus_err        (bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one access in flight, with its age in wait cycles.
  logic        m_pend = 1'b0;
  int          m_age  = 0;
  logic        m_we, m_rw, m_mtr;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_wreg;
  logic        e_rw = 1'b0, e_mtr = 1'b0, e_aerr = 1'b0, e_berr = 1'b0;
  logic [31:0] e_rd = '0, e_alu = '0;
  logic [4:0]  e_wreg = '0;

  always @(negedge clk) begin : cmp
    logic        memop, aligned, tmo, x_req, x_we, x_stall, x_pcsrc;
    logic [31:0] x_addr, x_wdata;
    if (!reset) begin
      m_pend = 1'b0; m_age = 0;
      e_rw = 1'b0; e_mtr = 1'b0; e_rd = '0; e_alu = '0; e_wreg = '0;
      e_aerr = 1'b0; e_berr = 1'b0;
    end
    chk1 ("m_regwrite_out", regwrite_out, e_rw);
    chk1 ("m_memtoreg_out", memtoreg_out, e_mtr);
    chk32("m_read_data_out", read_data_out, e_rd);
    chk32("m_alu_result_out", alu_result_out, e_alu);
    chk32("m_write_reg_out", 32'(write_reg_out), 32'(e_wreg));
    chk1 ("m_addr_err", addr_err, e_aerr);
    chk1 ("m_bus_err", bus_err, e_berr);
    if (!reset) begin
      chk1("m_req_in_reset", dif.dmem_req, 1'b0);
    end else begin
      memop   = memread_in | memwrite_in;
      aligned = (alu_result_in[1:0] == 2'b00);
      tmo     = (m_age == T - 1);
      if (m_pend) begin
        x_req = 1'b1; x_we = m_we; x_addr = m_addr; x_wdata = m_wdata;
        x_stall = !dif.dmem_ready && !tmo;
        x_pcsrc = 1'b0;
      end else begin
        x_req = memop && aligned; x_we = memwrite_in;
        x_addr = alu_result_in; x_wdata = write_data_in;
        x_stall = x_req && !dif.dmem_ready;
        x_pcsrc = branch_in && zero_in;
      end
      chk1 ("m_dmem_req", dif.dmem_req, x_req);
      chk1 ("m_stall_out", stall_out, x_stall);
      chk1 ("m_pcsrc", pcsrc, x_pcsrc);
      chk32("m_branch_target", branch_target, branchaddr_in);
      if (x_req) begin
        chk1 ("m_dmem_we", dif.dmem_we, x_we);
        chk32("m_dmem_addr", dif.dmem_addr, x_addr);
        chk32("m_dmem_wdata", dif.dmem_wdata, x_wdata);
      end
      e_aerr = 1'b0;
      e_berr = 1'b0;
      if (m_pend) begin
        if (dif.dmem_ready) begin
          e_rw = m_rw; e_mtr = m_mtr; e_rd = dif.dmem_rdata; e_alu = m_addr; e_wreg = m_wreg;
          m_pend = 1'b0;
        end else begin
          e_rw = 1'b0; e_mtr = 1'b0;
          if (tmo) begin
            e_berr = 1'b1; m_pend = 1'b0;
          end else begin
            m_age++;
          end
        end
      end else if (memop && !aligned) begin
        e_rw = 1'b0; e_mtr = 1'b0; e_aerr = 1'b1;
      end else if (memop && !dif.dmem_ready) begin
        e_rw = 1'b0; e_mtr = 1'b0;
        m_pend = 1'b1; m_age = 0;
        m_we = memwrite_in; m_rw = regwrite_in; m_mtr = memtoreg_in;
        m_addr = alu_result_in; m_wdata = write_data_in; m_wreg = write_reg_in;
      end else begin
        e_rw = regwrite_in; e_mtr = memtoreg_in;
        e_rd = memop ? dif.dmem_rdata : 32'h0;
        e_alu = alu_result_in; e_wreg = write_reg_in;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    regwrite_in = 1'b0; memtoreg_in = 1'b0; branch_in = 1'b0; memread_in = 1'b0;
    memwrite_in = 1'b0; zero_in = 1'b0; alu_result_in = '0; write_data_in = '0;
    write_reg_in = '0; branchaddr_in = '0;
    dif.dmem_ready = 1'b0; dif.dmem_rdata = '0;
  endtask

  task automatic load_in(input logic [31:0] a, input logic rdy, input logic [31:0] rd);
    idle_in();
    memread_in = 1'b1; regwrite_in = 1'b1; memtoreg_in = 1'b1;
    alu_result_in = a; write_reg_in = 5'd3;
    dif.dmem_ready = rdy; dif.dmem_rdata = rd;
  endtask

  int stalls, berrs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_in();
    memread_in = 1'b1; alu_result_in = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1 ("rst_req", dif.dmem_req, 1'b0);
    chk1 ("rst_regwrite", regwrite_out, 1'b0);
    chk32("rst_read_data", read_data_out, 32'h0);
    chk1 ("rst_bus_err", bus_err, 1'b0);
    nxt(); idle_in(); reset = 1'b1;

    // Zero-latency load followed directly by a store that waits three cycles.
    nxt(); load_in(32'h40, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk1 ("t1_req", dif.dmem_req, 1'b1);
    chk1 ("t1_stall", stall_out, 1'b0);
    nxt(); idle_in();
    memwrite_in = 1'b1; alu_result_in = 32'h80; write_data_in = 32'h1234;
    @(negedge clk);
    chk32("t1_read_data", read_data_out, 32'hDEADBEEF);
    chk1 ("t1_regwrite", regwrite_out, 1'b1);
    chk1 ("t2_stall0", stall_out, 1'b1);
    chk1 ("t2_we", dif.dmem_we, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      memwrite_in = 1'b0; memread_in = 1'b1; alu_result_in = 32'h3000; write_data_in = 32'hFFFF;
      dif.dmem_ready = (i == 2);
      @(negedge clk);
      chk1 ("t2_stall", stall_out, i != 2);
      chk1 ("t2_req", dif.dmem_req, 1'b1);
      chk32("t2_addr", dif.dmem_addr, 32'h80);
      chk32("t2_wdata", dif.dmem_wdata, 32'h1234);
      chk1 ("t2_bubble", regwrite_out, 1'b0);
      chk32("t2_alu_held", alu_result_out, 32'h40);
    end
    nxt(); idle_in();
    @(negedge clk);
    chk32("t2_alu_done", alu_result_out, 32'h80);

    // Misaligned load is dropped.
    nxt(); load_in(32'h42, 1'b1, 32'h0);
    @(negedge clk);
    chk1("t3_req", dif.dmem_req, 1'b0);
    chk1("t3_stall", stall_out, 1'b0);
    nxt(); idle_in();
    @(negedge clk);
    chk1("t3_addr_err", addr_err, 1'b1);
    chk1("t3_regwrite", regwrite_out, 1'b0);
    nxt();
    @(negedge clk);
    chk1("t3_addr_err_end", addr_err, 1'b0);

    // Timeout, then a completion on the fourth cycle.
    for (int pass = 0; pass < 2; pass++) begin
      nxt(); load_in(32'h10, 1'b0, 32'h0);
      stalls = 0; berrs = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        stalls += int'(stall_out);
        berrs  += int'(bus_err);
        if (pass == 1 && i == 4) begin
          chk32("t4_read_data", read_data_out, 32'hCAFE0004);
          chk1 ("t4_regwrite", regwrite_out, 1'b1);
        end
        nxt(); idle_in();
        if (pass == 1 && i == 2) begin
          dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'hCAFE0004;
        end
      end
      chk32("t4_stalls", stalls, (pass == 0) ? 4 : 3);
      chk32("t4_bus_err", berrs, (pass == 0) ? 1 : 0);
    end

    // Branch resolution.
    branch_in = 1'b1; zero_in = 1'b1; branchaddr_in = 32'h100;
    @(negedge clk);
    chk1 ("t5_pcsrc", pcsrc, 1'b1);
    chk32("t5_target", branch_target, 32'h100);
    nxt(); zero_in = 1'b0;
    @(negedge clk);
    chk1("t5_pcsrc_nz", pcsrc, 1'b0);

    // Reset in the middle of a wait.
    nxt(); load_in(32'h20, 1'b0, 32'h0);
    @(negedge clk);
    chk1("t6_stall", stall_out, 1'b1);
    nxt(); idle_in();
    @(negedge clk);
    chk1("t6_req_wait", dif.dmem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1 ("t6_req_rst", dif.dmem_req, 1'b0);
    chk1 ("t6_regwrite_rst", regwrite_out, 1'b0);
    chk32("t6_alu_rst", alu_result_out, 32'h0);
    nxt(); nxt(); reset = 1'b1;
    load_in(32'h24, 1'b1, 32'h55AA);
    @(negedge clk);
    chk1("t6_req_new", dif.dmem_req, 1'b1);
    chk1("t6_stall_new", stall_out, 1'b0);
    nxt(); idle_in();
    @(negedge clk);
    chk32("t6_read_data", read_data_out, 32'h55AA);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset         = ($urandom_range(0, 299) != 0);
      regwrite_in   = 1'($urandom_range(0, 1));
      memtoreg_in   = 1'($urandom_range(0, 1));
      branch_in     = 1'($urandom_range(0, 1));
      zero_in       = 1'($urandom_range(0, 1));
      memread_in    = 1'($urandom_range(0, 1));
      memwrite_in   = ($urandom_range(0, 2) == 0);
      alu_result_in = $urandom;
      if ($urandom_range(0, 3) != 0) alu_result_in[1:0] = 2'b00;
      write_data_in = $urandom;
      write_reg_in  = 5'($urandom_range(0, 31));
      branchaddr_in = $urandom;
      dif.dmem_ready = ($urandom_range(0, 2) == 0);
      dif.dmem_rdata = $urandom;
    end
    nxt();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
